dual_ram_arbiter_2ch: RTL and testbench

// - Shares one 8x16 dual-port RAM (independent write port and read port, registered read data) between two clients, C0 and C1.
// - Arbitrates the write port and the read port separately with round-robin priority, so one read and one write can complete in the same cycle.
// - Resolves same-address read/write collisions so that a reader always sees post-write data.
// - Sits between client logic and the RAM instance; this block owns every RAM port.

---
 rtl/dual_ram_pkg.sv | 11 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/dual_ram_arbiter_2ch.sv | 107 ++++++++++
 tb/tb_dual_ram_arbiter_2ch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_ram_pkg.sv
// Shared constants for the two-client dual-port RAM arbiter.
package dual_ram_pkg;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 8;
  localparam int ADDR_BUS = 3;

  localparam int C0 = 0;
  localparam int C1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the requests and
// the registered last winner; the last winner only moves when the grant is
// actually used (en), so a withheld grant keeps its priority.
module rr_arb2
  import dual_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // Pick the winner: a lone requester wins, on contention the client that did not win last time wins.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (en && (gnt != 2'b00)) begin
      last_d = gnt[C1];
    end
  end

  // Last-winner register; reset to C1 so that C0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dual_ram_arbiter_2ch.sv
// Shares one dual-port RAM between two clients. The write and read ports are
// arbitrated independently; a same-address read/write pair alternates between
// letting the write through and letting the read through, so a reader never
// sees stale data and is held off for at most one cycle.
module dual_ram_arbiter_2ch
  import dual_ram_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                c0_req,
  input  logic                c0_we,
  input  logic [ADDR_BUS-1:0] c0_addr,
  input  logic [WIDTH-1:0]    c0_wdata,
  output logic                c0_ack,
  output logic                c0_rvalid,
  output logic [WIDTH-1:0]    c0_rdata,
  input  logic                c1_req,
  input  logic                c1_we,
  input  logic [ADDR_BUS-1:0] c1_addr,
  input  logic [WIDTH-1:0]    c1_wdata,
  output logic                c1_ack,
  output logic                c1_rvalid,
  output logic [WIDTH-1:0]    c1_rdata,
  output logic                ram_rst,
  output logic                ram_we,
  output logic                ram_re,
  output logic [ADDR_BUS-1:0] ram_wr_addr,
  output logic [ADDR_BUS-1:0] ram_rd_addr,
  output logic [WIDTH-1:0]    ram_din,
  input  logic [WIDTH-1:0]    ram_dout
);

  logic [1:0]          wr_cand;
  logic [1:0]          rd_cand;
  logic [1:0]          wr_gnt;
  logic [1:0]          rd_gnt;
  logic                wr_go;
  logic                rd_go;
  logic                collide;
  logic [ADDR_BUS-1:0] wr_addr;
  logic [ADDR_BUS-1:0] rd_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                rd_defer_q;
  logic                rd_defer_d;
  logic [1:0]          rvalid_q;
  logic [1:0]          rvalid_d;

  // Split the requests into write-port and read-port candidates.
  always_comb begin
    wr_cand = {c1_req & c1_we,  c0_req & c0_we};
    rd_cand = {c1_req & ~c1_we, c0_req & ~c0_we};
  end

  rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (wr_cand),
    .en  (wr_go),
    .gnt (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (rd_cand),
    .en  (rd_go),
    .gnt (rd_gnt)
  );

  // Resolve collisions, drive the RAM ports and acknowledge the winners.
  always_comb begin
    wr_addr = wr_gnt[C1] ? c1_addr  : c0_addr;
    wr_data = wr_gnt[C1] ? c1_wdata : c0_wdata;
    rd_addr = rd_gnt[C1] ? c1_addr  : c0_addr;
    collide = (|wr_gnt) & (|rd_gnt) & (wr_addr == rd_addr);
    // Write goes first on a fresh collision; the deferred read goes next time.
    wr_go      = rst & (|wr_gnt) & ~(collide & rd_defer_q);
    rd_go      = rst & (|rd_gnt) & ~(collide & ~rd_defer_q);
    rd_defer_d = collide & ~rd_defer_q;
    rvalid_d   = rd_go ? rd_gnt : 2'b00;
    c0_ack      = (wr_go & wr_gnt[C0]) | (rd_go & rd_gnt[C0]);
    c1_ack      = (wr_go & wr_gnt[C1]) | (rd_go & rd_gnt[C1]);
    ram_we      = wr_go;
    ram_re      = rd_go;
    ram_wr_addr = wr_addr;
    ram_rd_addr = rd_addr;
    ram_din     = wr_data;
  end

  // Collision-defer flag and the read-owner pipeline that qualifies ram_dout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_defer_q <= 1'b0;
      rvalid_q   <= 2'b00;
    end else begin
      rd_defer_q <= rd_defer_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign ram_rst   = ~rst;
  assign c0_rvalid = rvalid_q[C0];
  assign c1_rvalid = rvalid_q[C1];
  assign c0_rdata  = ram_dout;
  assign c1_rdata  = ram_dout;

endmodule

// File: tb/tb_dual_ram_arbiter_2ch.sv
// Bench for dual_ram_arbiter_2ch with an 8x16 registered-read RAM attached.
module tb_dual_ram_arbiter_2ch;
  import dual_ram_pkg::*;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wd;
  } op_t;

  logic        clk;
  logic        rst;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [2:0]  c0_addr, c1_addr;
  logic [15:0] c0_wdata, c1_wdata;
  logic        c0_ack, c0_rvalid, c1_ack, c1_rvalid;
  logic [15:0] c0_rdata, c1_rdata;
  logic        ram_rst, ram_we, ram_re;
  logic [2:0]  ram_wr_addr, ram_rd_addr;
  logic [15:0] ram_din, ram_dout;

  dual_ram_arbiter_2ch dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .ram_rst(ram_rst), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8x16 dual-port RAM, registered read, cleared by ram_rst.
  logic [15:0] ram_mem [0:7];
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 8; i++) ram_mem[i] <= 16'h0000;
      ram_dout <= 16'h0000;
    end else begin
      if (ram_we) ram_mem[ram_wr_addr] <= ram_din;
      if (ram_re) ram_dout <= ram_mem[ram_rd_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;
  int pstart = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Client request queues and per-phase logs of what the DUT did.
  op_t q0[$];
  op_t q1[$];
  int  ack0_log[$], ack1_log[$], rv0_cyc[$], rv1_cyc[$], rv0_dat[$], rv1_dat[$];
  bit  ack0_seen = 1'b0;
  bit  ack1_seen = 1'b0;

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Reference model: plain integers for last winners, a defer flag, a memory image.
  int          m_wlast = 1;
  int          m_rlast = 1;
  bit          m_defer = 1'b0;
  bit          m_pv    = 1'b0;
  int          m_po    = 0;
  logic [15:0] m_pd    = 16'h0000;
  logic [15:0] m_mem [0:7];
  int          w, r;
  bit          coll;
  logic [2:0]  wa, ra;
  logic [15:0] wdv;

  function automatic int pick(input bit a0, input bit a1, input int last);
    if (a0 && a1) return (last == 0) ? 1 : 0;
    if (a0) return 0;
    if (a1) return 1;
    return -1;
  endfunction

  // Compare process: every falling edge, check DUT against model, then advance model.
  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    forever begin
      @(negedge clk);
      ncyc++;
      w = rst ? pick(c0_req & c0_we,  c1_req & c1_we,  m_wlast) : -1;
      r = rst ? pick(c0_req & !c0_we, c1_req & !c1_we, m_rlast) : -1;
      wa  = (w == 1) ? c1_addr  : c0_addr;
      wdv = (w == 1) ? c1_wdata : c0_wdata;
      ra  = (r == 1) ? c1_addr  : c0_addr;
      coll = (w >= 0) && (r >= 0) && (wa == ra);
      if (coll) begin
        if (m_defer) w = -1;
        else         r = -1;
      end
      chk("c0_ack", c0_ack, (w == 0) || (r == 0));
      chk("c1_ack", c1_ack, (w == 1) || (r == 1));
      chk("ram_we", ram_we, w >= 0);
      chk("ram_re", ram_re, r >= 0);
      chk("ram_rst", ram_rst, !rst);
      if (w >= 0) begin
        chk("ram_wr_addr", ram_wr_addr, wa);
        chk("ram_din", ram_din, wdv);
      end
      if (r >= 0) chk("ram_rd_addr", ram_rd_addr, ra);
      chk("c0_rvalid", c0_rvalid, m_pv && (m_po == 0));
      chk("c1_rvalid", c1_rvalid, m_pv && (m_po == 1));
      if (m_pv && m_po == 0) chk("c0_rdata", c0_rdata, m_pd);
      if (m_pv && m_po == 1) chk("c1_rdata", c1_rdata, m_pd);

      if (c0_ack) ack0_log.push_back(ncyc - pstart);
      if (c1_ack) ack1_log.push_back(ncyc - pstart);
      if (c0_rvalid) begin rv0_cyc.push_back(ncyc - pstart); rv0_dat.push_back(int'(c0_rdata)); end
      if (c1_rvalid) begin rv1_cyc.push_back(ncyc - pstart); rv1_dat.push_back(int'(c1_rdata)); end
      ack0_seen = c0_ack;
      ack1_seen = c1_ack;

      if (!rst) begin
        m_wlast = 1; m_rlast = 1; m_defer = 1'b0; m_pv = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
      end else begin
        m_pv = (r >= 0);
        m_po = r;
        if (r >= 0) begin m_pd = m_mem[ra]; m_rlast = r; end
        if (w >= 0) begin m_mem[wa] = wdv; m_wlast = w; end
        m_defer = coll && !m_defer;
      end
    end
  end

  task automatic drive();
    if (q0.size() > 0) begin
      c0_req = 1'b1; c0_we = q0[0].we; c0_addr = q0[0].addr; c0_wdata = q0[0].wd;
    end else c0_req = 1'b0;
    if (q1.size() > 0) begin
      c1_req = 1'b1; c1_we = q1[0].we; c1_addr = q1[0].addr; c1_wdata = q1[0].wd;
    end else c1_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ack0_seen && q0.size() > 0) q0.delete(0);
    if (ack1_seen && q1.size() > 0) q1.delete(0);
    drive();
  endtask

  task automatic phase_begin();
    ack0_log.delete(); ack1_log.delete();
    rv0_cyc.delete(); rv1_cyc.delete(); rv0_dat.delete(); rv1_dat.delete();
    pstart = ncyc;
  endtask

  task automatic push(input int c, input bit we, input logic [2:0] a, input logic [15:0] d);
    op_t op;
    op.we = we; op.addr = a; op.wd = d;
    if (c == 0) q0.push_back(op);
    else        q1.push_back(op);
  endtask

  task automatic run_phase(input int budget);
    int n;
    n = 0;
    drive();
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("phase_drained", q0.size() + q1.size(), 0);
    if (q0.size() > 0 || q1.size() > 0) begin
      q0.delete(); q1.delete(); drive();
    end
    step();
    step();
  endtask

  initial begin
    rst = 1'b0;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = 3'd0; c0_wdata = 16'h0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = 3'd0; c1_wdata = 16'h0;

    // Reset with a read already pending: no ack until reset releases.
    push(0, 1'b0, 3'd5, 16'h0);
    drive();
    step(); step(); step();
    chk("rst_ram_rst", ram_rst, 1'b1);
    chk("rst_c0_ack", c0_ack, 1'b0);
    chk("rst_rvalid", {c0_rvalid, c1_rvalid}, 2'b00);
    phase_begin();
    rst = 1'b1;
    run_phase(20);
    chk("rd5_ack_cyc", qget(ack0_log, 0), 1);
    chk("rd5_rvalid_cyc", qget(rv0_cyc, 0), 2);
    chk("rd5_data", qget(rv0_dat, 0), 32'h0000);

    // Write contention: C0 first, C1 next.
    phase_begin();
    push(0, 1'b1, 3'd1, 16'hAAAA);
    push(1, 1'b1, 3'd2, 16'h5555);
    run_phase(20);
    chk("wcont_c0_ack", qget(ack0_log, 0), 1);
    chk("wcont_c1_ack", qget(ack1_log, 0), 2);

    phase_begin();
    push(0, 1'b0, 3'd1, 16'h0);
    push(1, 1'b0, 3'd2, 16'h0);
    run_phase(20);
    chk("rb_c0_data", qget(rv0_dat, 0), 32'hAAAA);
    chk("rb_c1_data", qget(rv1_dat, 0), 32'h5555);

    // Concurrent ports: write and read on different addresses in one cycle.
    phase_begin();
    push(0, 1'b1, 3'd3, 16'h1234);
    push(1, 1'b0, 3'd4, 16'h0);
    run_phase(20);
    chk("conc_c0_ack", qget(ack0_log, 0), 1);
    chk("conc_c1_ack", qget(ack1_log, 0), 1);
    chk("conc_c1_rv_cyc", qget(rv1_cyc, 0), 2);
    chk("conc_c1_data", qget(rv1_dat, 0), 32'h0000);

    // Collision on addr 6.
    push(0, 1'b1, 3'd6, 16'h0001);
    run_phase(20);
    phase_begin();
    push(0, 1'b1, 3'd6, 16'hBEEF);
    push(1, 1'b0, 3'd6, 16'h0);
    run_phase(20);
    chk("coll_c0_ack", qget(ack0_log, 0), 1);
    chk("coll_c1_ack", qget(ack1_log, 0), 2);
    chk("coll_c1_rv_cyc", qget(rv1_cyc, 0), 3);
    chk("coll_c1_data", qget(rv1_dat, 0), 32'hBEEF);

    // Anti-starvation: C0 hammers addr 7, C1 reads it.
    phase_begin();
    push(0, 1'b1, 3'd7, 16'h1111);
    push(0, 1'b1, 3'd7, 16'h2222);
    push(0, 1'b1, 3'd7, 16'h3333);
    push(1, 1'b0, 3'd7, 16'h0);
    run_phase(20);
    chk("starv_c1_ack", qget(ack1_log, 0), 2);
    chk("starv_c0_ack0", qget(ack0_log, 0), 1);
    chk("starv_c0_ack1", qget(ack0_log, 1), 3);
    chk("starv_c0_ack2", qget(ack0_log, 2), 4);
    chk("starv_c1_data", qget(rv1_dat, 0), 32'h1111);

    // Fairness: both clients read back-to-back.
    phase_begin();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 3'd1, 16'h0);
      push(1, 1'b0, 3'd2, 16'h0);
    end
    run_phase(30);
    for (int i = 0; i < 4; i++) begin
      chk("fair_c0_ack", qget(ack0_log, i), 2 * i + 1);
      chk("fair_c1_ack", qget(ack1_log, i), 2 * i + 2);
    end
    chk("fair_c0_nrv", rv0_dat.size(), 4);
    chk("fair_c1_nrv", rv1_dat.size(), 4);
    chk("fair_c0_data", qget(rv0_dat, 3), 32'hAAAA);
    chk("fair_c1_data", qget(rv1_dat, 3), 32'h5555);

    // Second reset clears RAM contents.
    rst = 1'b0;
    step(); step();
    chk("rst2_ram_rst", ram_rst, 1'b1);
    phase_begin();
    rst = 1'b1;
    push(1, 1'b0, 3'd1, 16'h0);
    run_phase(20);
    chk("rst2_c1_data", qget(rv1_dat, 0), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
